// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path.
// Contents: supported opcodes, FSM state encoding and the datapath select
// encodings driven by multicycle_ctrl_fsm.
package riscv_ctrl_pkg;

    // Supported opcodes (IR[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    // ALU operation class
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // Immediate format
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Result mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU source A
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU source B
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for the memory-handshake states.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       restart the count at zero (state entry)
//   enable      count one more wait cycle
//   done        count has reached TIMEOUT_CYCLES (never set when TIMEOUT_CYCLES = 0)
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_r;

    // Wait-cycle counter; clear has priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Terminal-count flag; a zero limit disables the timeout entirely
    always_comb begin
        if (TIMEOUT_CYCLES != 0) begin
            done = (cnt_r == LIMIT);
        end else begin
            done = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for a multicycle RV32I datapath (lw, sw, R, I, beq, jal).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   op, zero        opcode IR[6:0], ALU zero flag
//   mem_ready       memory handshake for the current access
//   mem_req/mem_write/adr_src          memory port control
//   ir_write/pc_write/reg_write        register enables
//   result_src/alu_src_a/alu_src_b/alu_op/imm_src  datapath selects
//   illegal_op, bus_err                1-cycle error pulses
//   instret         retired-instruction counter
// Outputs are decoded from the state register (ir_write, pc_write,
// mem_write also look at inputs) and forced low while rst_n is low, so a
// reset mid-access removes the write strobe immediately.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_src,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    state_t state_r;
    state_t state_next_s;
    logic   hold_s;       // waiting in a memory state, counter keeps running
    logic   tmo_s;        // wait budget exhausted
    logic   retire_s;
    logic   pc_update_s;
    logic   branch_s;

    // Any cycle that does not hold restarts the count, so every state entry
    // (including FETCH re-entered after a timeout) starts from zero.
    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (~hold_s),
        .enable(hold_s),
        .done  (tmo_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            instret <= instret + CNT_W'(1);
        end
    end

    // Immediate format straight from the opcode, independent of state and reset
    always_comb begin
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

    // Next-state and per-state datapath controls
    always_comb begin
        state_next_s = state_r;
        hold_s       = 1'b0;
        retire_s     = 1'b0;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        result_src   = RES_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALU_OP_ADD;
        illegal_op   = 1'b0;
        bus_err      = 1'b0;

        if (!rst_n) begin
            state_next_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH: begin
                    // Request is withdrawn in the timeout cycle; a late
                    // mem_ready in that same cycle still completes the fetch.
                    mem_req    = ~tmo_s;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    alu_op     = ALU_OP_ADD;
                    result_src = RES_ALURESULT;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        pc_update_s  = 1'b1;
                        state_next_s = S_DECODE;
                    end else if (tmo_s) begin
                        bus_err      = 1'b1;
                        state_next_s = S_FETCH;
                    end else begin
                        hold_s = 1'b1;
                    end
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_OP_ADD;
                    case (op)
                        OP_LW, OP_SW: state_next_s = S_MEMADR;
                        OP_R:         state_next_s = S_EXECR;
                        OP_I:         state_next_s = S_EXECI;
                        OP_BEQ:       state_next_s = S_BEQ;
                        OP_JAL:       state_next_s = S_JAL;
                        default: begin
                            illegal_op   = 1'b1;
                            state_next_s = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_OP_ADD;
                    if (op == OP_LW) begin
                        state_next_s = S_MEMREAD;
                    end else if (op == OP_SW) begin
                        state_next_s = S_MEMWRITE;
                    end else begin
                        state_next_s = S_FETCH;
                    end
                end
                S_MEMREAD: begin
                    mem_req = ~tmo_s;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        state_next_s = S_MEMWB;
                    end else if (tmo_s) begin
                        bus_err      = 1'b1;
                        state_next_s = S_FETCH;
                    end else begin
                        hold_s = 1'b1;
                    end
                end
                S_MEMWB: begin
                    result_src   = RES_DATA;
                    reg_write    = 1'b1;
                    retire_s     = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req   = ~tmo_s;
                    mem_write = ~tmo_s;
                    adr_src   = 1'b1;
                    if (mem_ready) begin
                        retire_s     = 1'b1;
                        state_next_s = S_FETCH;
                    end else if (tmo_s) begin
                        bus_err      = 1'b1;
                        state_next_s = S_FETCH;
                    end else begin
                        hold_s = 1'b1;
                    end
                end
                S_EXECR: begin
                    alu_src_a    = SRCA_RS1;
                    alu_src_b    = SRCB_RS2;
                    alu_op       = ALU_OP_FUNCT;
                    state_next_s = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a    = SRCA_RS1;
                    alu_src_b    = SRCB_IMM;
                    alu_op       = ALU_OP_FUNCT;
                    state_next_s = S_ALUWB;
                end
                S_ALUWB: begin
                    result_src   = RES_ALUOUT;
                    reg_write    = 1'b1;
                    retire_s     = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_BEQ: begin
                    alu_src_a    = SRCA_RS1;
                    alu_src_b    = SRCB_RS2;
                    alu_op       = ALU_OP_SUB;
                    result_src   = RES_ALUOUT;
                    branch_s     = 1'b1;
                    retire_s     = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_JAL: begin
                    // Link value PC+4 is produced here; ALUWB writes and retires it
                    alu_src_a    = SRCA_OLDPC;
                    alu_src_b    = SRCB_FOUR;
                    alu_op       = ALU_OP_ADD;
                    result_src   = RES_ALUOUT;
                    pc_update_s  = 1'b1;
                    state_next_s = S_ALUWB;
                end
                default: begin
                    state_next_s = S_FETCH;
                end
            endcase
        end

        pc_write = pc_update_s | (branch_s & zero);
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm (TIMEOUT_CYCLES = 4).
// Each cycle the expected control vector is pushed to a scoreboard queue when
// the inputs are driven and popped/compared at the following falling edge.
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_ILL = 7'b0001111;

    localparam int B_F = 0, B_D = 1, B_MA = 2, B_MR = 3, B_MWB = 4, B_MW = 5;
    localparam int B_ER = 6, B_EI = 7, B_AWB = 8, B_BEQ = 9, B_JAL = 10;

    typedef struct {
        logic [15:0] sig;
        logic [1:0]  imm;
        logic [31:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  op = 7'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic        illegal_op, bus_err;
    logic [31:0] instret;
    logic [15:0] obs_sig;

    exp_t        exp_q[$];
    logic [31:0] model_ret = 32'd0;
    int          vectors = 0;
    int          miscompares = 0;

    multicycle_ctrl_fsm #(
        .TIMEOUT_CYCLES(4),
        .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .illegal_op(illegal_op),
        .bus_err(bus_err), .instret(instret)
    );

    always #5 clk = ~clk;

    assign obs_sig = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                      result_src, alu_src_a, alu_src_b, alu_op, illegal_op, bus_err};

    function automatic logic is_illegal(input logic [6:0] o);
        return !(o == T_LW || o == T_SW || o == T_R || o == T_I || o == T_BEQ || o == T_JAL);
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == T_SW) return 2'b01;
        else if (o == T_BEQ) return 2'b10;
        else if (o == T_JAL) return 2'b11;
        else return 2'b00;
    endfunction

    // Expected control vector for a given state, inputs and timeout condition
    function automatic logic [15:0] exp_sig(input int st, input logic rdy, input logic z,
                                            input logic to, input logic ill);
        logic mreq, mw, adr, irw, pcw, rw, il, be;
        logic [1:0] res, a, b, aop;
        mreq = 1'b0; mw = 1'b0; adr = 1'b0; irw = 1'b0; pcw = 1'b0; rw = 1'b0;
        il = 1'b0; be = 1'b0; res = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
        case (st)
            B_F:   begin mreq = !to; irw = rdy; pcw = rdy; res = 2'b10; b = 2'b10; be = to & !rdy; end
            B_D:   begin a = 2'b01; b = 2'b01; il = ill; end
            B_MA:  begin a = 2'b10; b = 2'b01; end
            B_MR:  begin mreq = !to; adr = 1'b1; be = to & !rdy; end
            B_MWB: begin res = 2'b01; rw = 1'b1; end
            B_MW:  begin mreq = !to; mw = !to; adr = 1'b1; be = to & !rdy; end
            B_ER:  begin a = 2'b10; aop = 2'b10; end
            B_EI:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            B_AWB: begin rw = 1'b1; end
            B_BEQ: begin a = 2'b10; aop = 2'b01; pcw = z; end
            B_JAL: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            default: begin end
        endcase
        return {mreq, mw, adr, irw, pcw, rw, res, a, b, aop, il, be};
    endfunction

    // Step encoding: {op, state, mem_ready, zero, timeout_expected}
    function automatic logic [13:0] stp(input logic [6:0] o, input int st, input logic r,
                                        input logic z, input logic t);
        logic [3:0] s4;
        s4 = st[3:0];
        return {o, s4, r, z, t};
    endfunction

    // Drive one cycle of stimulus and push what the DUT must show for it
    task automatic drive_cycle(input logic [13:0] s);
        exp_t e;
        int   st;
        @(posedge clk);
        #1;
        op = s[13:7];
        st = int'(s[6:3]);
        mem_ready = s[2];
        zero = s[1];
        e.sig = exp_sig(st, s[2], s[1], s[0], is_illegal(s[13:7]));
        e.imm = exp_imm(s[13:7]);
        e.ret = model_ret;
        exp_q.push_back(e);
        if (st == B_MWB || st == B_AWB || st == B_BEQ || (st == B_MW && s[2]))
            model_ret = model_ret + 32'd1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; op = T_R; mem_ready = 1'b1; zero = 1'b0; model_ret = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) rst_n = 1'b1;
            e.sig = (i == 3) ? exp_sig(B_F, 1'b1, 1'b0, 1'b0, 1'b0) : 16'h0000;
            e.imm = exp_imm(op);
            e.ret = model_ret;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs_sig !== e.sig) begin miscompares++; $display("FAIL reset[%0d] ctrl got %h exp %h", i, obs_sig, e.sig); end
            vectors++;
            if (instret !== e.ret) begin miscompares++; $display("FAIL reset[%0d] instret got %0d exp %0d", i, instret, e.ret); end
            vectors++;
            if (imm_src !== e.imm) begin miscompares++; $display("FAIL reset[%0d] imm_src got %b exp %b", i, imm_src, e.imm); end
        end
    endtask

    task automatic test_rtype();
        logic [13:0] sc[$];
        exp_t e;
        sc.push_back(stp(T_R, B_D, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_R, B_ER, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_R, B_AWB, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < sc.size(); i++) begin
            drive_cycle(sc[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs_sig !== e.sig) begin miscompares++; $display("FAIL rtype[%0d] ctrl got %h exp %h", i, obs_sig, e.sig); end
            vectors++;
            if (instret !== e.ret) begin miscompares++; $display("FAIL rtype[%0d] instret got %0d exp %0d", i, instret, e.ret); end
            vectors++;
            if (imm_src !== e.imm) begin miscompares++; $display("FAIL rtype[%0d] imm_src got %b exp %b", i, imm_src, e.imm); end
        end
    endtask

    task automatic test_wait_states();
        logic [13:0] sc[$];
        exp_t e;
        for (int k = 0; k < 3; k++) sc.push_back(stp(T_LW, B_F, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_LW, B_F, 1'b1, 1'b0, 1'b0));
        sc.push_back(stp(T_LW, B_D, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_LW, B_MA, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_LW, B_MR, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_LW, B_MR, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_LW, B_MR, 1'b1, 1'b0, 1'b0));
        sc.push_back(stp(T_LW, B_MWB, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < sc.size(); i++) begin
            drive_cycle(sc[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs_sig !== e.sig) begin miscompares++; $display("FAIL lw_wait cycle %0d ctrl got %h exp %h", i + 1, obs_sig, e.sig); end
            vectors++;
            if (instret !== e.ret) begin miscompares++; $display("FAIL lw_wait cycle %0d instret got %0d exp %0d", i + 1, instret, e.ret); end
            vectors++;
            if (imm_src !== e.imm) begin miscompares++; $display("FAIL lw_wait cycle %0d imm_src got %b exp %b", i + 1, imm_src, e.imm); end
        end
    endtask

    task automatic test_sw_itype();
        logic [13:0] sc[$];
        exp_t e;
        sc.push_back(stp(T_SW, B_F, 1'b1, 1'b0, 1'b0));
        sc.push_back(stp(T_SW, B_D, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_SW, B_MA, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_SW, B_MW, 1'b1, 1'b0, 1'b0));
        sc.push_back(stp(T_I, B_F, 1'b1, 1'b0, 1'b0));
        sc.push_back(stp(T_I, B_D, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_I, B_EI, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_I, B_AWB, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < sc.size(); i++) begin
            drive_cycle(sc[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs_sig !== e.sig) begin miscompares++; $display("FAIL sw_i[%0d] ctrl got %h exp %h", i, obs_sig, e.sig); end
            vectors++;
            if (instret !== e.ret) begin miscompares++; $display("FAIL sw_i[%0d] instret got %0d exp %0d", i, instret, e.ret); end
            vectors++;
            if (imm_src !== e.imm) begin miscompares++; $display("FAIL sw_i[%0d] imm_src got %b exp %b", i, imm_src, e.imm); end
        end
    endtask

    task automatic test_branch();
        logic [13:0] sc[$];
        exp_t e;
        sc.push_back(stp(T_BEQ, B_F, 1'b1, 1'b1, 1'b0));
        sc.push_back(stp(T_BEQ, B_D, 1'b0, 1'b1, 1'b0));
        sc.push_back(stp(T_BEQ, B_BEQ, 1'b0, 1'b1, 1'b0));
        sc.push_back(stp(T_BEQ, B_F, 1'b1, 1'b0, 1'b0));
        sc.push_back(stp(T_BEQ, B_D, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_BEQ, B_BEQ, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < sc.size(); i++) begin
            drive_cycle(sc[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs_sig !== e.sig) begin miscompares++; $display("FAIL beq[%0d] ctrl got %h exp %h", i, obs_sig, e.sig); end
            vectors++;
            if (instret !== e.ret) begin miscompares++; $display("FAIL beq[%0d] instret got %0d exp %0d", i, instret, e.ret); end
            vectors++;
            if (imm_src !== e.imm) begin miscompares++; $display("FAIL beq[%0d] imm_src got %b exp %b", i, imm_src, e.imm); end
        end
    endtask

    task automatic test_illegal_jal();
        logic [13:0] sc[$];
        exp_t e;
        sc.push_back(stp(T_ILL, B_F, 1'b1, 1'b0, 1'b0));
        sc.push_back(stp(T_ILL, B_D, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_JAL, B_F, 1'b1, 1'b0, 1'b0));
        sc.push_back(stp(T_JAL, B_D, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_JAL, B_JAL, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_JAL, B_AWB, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < sc.size(); i++) begin
            drive_cycle(sc[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs_sig !== e.sig) begin miscompares++; $display("FAIL ill_jal[%0d] ctrl got %h exp %h", i, obs_sig, e.sig); end
            vectors++;
            if (instret !== e.ret) begin miscompares++; $display("FAIL ill_jal[%0d] instret got %0d exp %0d", i, instret, e.ret); end
            vectors++;
            if (imm_src !== e.imm) begin miscompares++; $display("FAIL ill_jal[%0d] imm_src got %b exp %b", i, imm_src, e.imm); end
        end
    endtask

    task automatic test_timeout();
        logic [13:0] sc[$];
        exp_t e;
        sc.push_back(stp(T_SW, B_F, 1'b1, 1'b0, 1'b0));
        sc.push_back(stp(T_SW, B_D, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_SW, B_MA, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 4; k++) sc.push_back(stp(T_SW, B_MW, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_SW, B_MW, 1'b0, 1'b0, 1'b1));
        sc.push_back(stp(T_SW, B_F, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_SW, B_F, 1'b1, 1'b0, 1'b0));
        sc.push_back(stp(T_SW, B_D, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_SW, B_MA, 1'b0, 1'b0, 1'b0));
        sc.push_back(stp(T_SW, B_MW, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < sc.size(); i++) begin
            drive_cycle(sc[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs_sig !== e.sig) begin miscompares++; $display("FAIL timeout[%0d] ctrl got %h exp %h", i, obs_sig, e.sig); end
            vectors++;
            if (instret !== e.ret) begin miscompares++; $display("FAIL timeout[%0d] instret got %0d exp %0d", i, instret, e.ret); end
            vectors++;
            if (imm_src !== e.imm) begin miscompares++; $display("FAIL timeout[%0d] imm_src got %b exp %b", i, imm_src, e.imm); end
        end
        // Now mid-MEMWRITE with mem_write high: reset between clock edges
        #2;
        rst_n = 1'b0;
        model_ret = 32'd0;
        #1;
        vectors++;
        if (mem_write !== 1'b0) begin miscompares++; $display("FAIL rst_midwrite mem_write got %b exp 0", mem_write); end
        vectors++;
        if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_midwrite mem_req got %b exp 0", mem_req); end
        vectors++;
        if (instret !== model_ret) begin miscompares++; $display("FAIL rst_midwrite instret got %0d exp %0d", instret, model_ret); end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs_sig !== exp_sig(B_F, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL post_reset ctrl got %h exp %h", obs_sig, exp_sig(B_F, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_wait_states();
        test_sw_itype();
        test_branch();
        test_illegal_jal();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
